// File: rtl/hdlc_deframer.sv
`default_nettype none
// ============================================================================
// Module  : hdlc_deframer
// Brief   : HDLC receive deframer. A one-hot bit-stuffing detector feeds a
//           HUNT/SYNC/DATA frame FSM that strips stuffed zeros, finds flags
//           and assembles payload bytes LSB-first.
// Revision: 1.0  initial release
// ============================================================================
module hdlc_deframer #(
  parameter int MIN_BYTES = 4,
  parameter int MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       din_valid,
  input  logic       din,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_abort,
  output logic       in_frame
);

  localparam int CW = $clog2(MAX_BYTES + 2);

  localparam logic [9:0] S0 = 10'b0000000001;
  localparam logic [9:0] S1 = 10'b0000000010;
  localparam logic [9:0] S2 = 10'b0000000100;
  localparam logic [9:0] S3 = 10'b0000001000;
  localparam logic [9:0] S4 = 10'b0000010000;
  localparam logic [9:0] S5 = 10'b0000100000;
  localparam logic [9:0] S6 = 10'b0001000000;
  localparam logic [9:0] S7 = 10'b0010000000;
  localparam logic [9:0] S8 = 10'b0100000000;
  localparam logic [9:0] S9 = 10'b1000000000;

  localparam logic [CW-1:0] C_MIN_BYTES = CW'(MIN_BYTES);
  localparam logic [CW-1:0] C_MAX_BYTES = CW'(MAX_BYTES);
  localparam logic [CW-1:0] C_SAT_BYTES = CW'(MAX_BYTES + 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } frame_state_t;

  logic [9:0]    r_det;
  logic [9:0]    w_det_next;
  frame_state_t  r_state;
  logic [2:0]    r_bit_cnt;
  logic [CW-1:0] r_byte_cnt;
  logic [7:0]    r_asm;
  logic [7:0]    w_asm_next;
  logic          w_is_discard;
  logic          w_is_flag;
  logic          w_is_error;
  logic          w_is_data;

  // Detector counts consecutive ones; S8/S9 mark stuffed zero / flag closure.
  always_comb begin
    w_det_next = S0;
    case (r_det)
      S0:      w_det_next = din ? S1 : S0;
      S1:      w_det_next = din ? S2 : S0;
      S2:      w_det_next = din ? S3 : S0;
      S3:      w_det_next = din ? S4 : S0;
      S4:      w_det_next = din ? S5 : S0;
      S5:      w_det_next = din ? S6 : S8;
      S6:      w_det_next = din ? S7 : S9;
      S7:      w_det_next = din ? S7 : S0;
      S8, S9:  w_det_next = din ? S1 : S0;
      default: w_det_next = S0;
    endcase
  end

  always_comb begin
    w_is_discard = (w_det_next == S8);
    w_is_flag    = (w_det_next == S9);
    w_is_error   = (w_det_next == S7);
    w_is_data    = !(w_is_discard || w_is_flag || w_is_error);
    w_asm_next   = r_asm;
    w_asm_next[r_bit_cnt] = din;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_det       <= S0;
      r_state     <= HUNT;
      r_bit_cnt   <= 3'd0;
      r_byte_cnt  <= '0;
      r_asm       <= 8'h00;
      byte_valid  <= 1'b0;
      byte_data   <= 8'h00;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      in_frame    <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_abort <= 1'b0;
      if (din_valid) begin
        r_det <= w_det_next;
        case (r_state)
          HUNT: begin
            if (w_is_flag) begin
              r_state    <= SYNC;
              r_bit_cnt  <= 3'd0;
              r_byte_cnt <= '0;
            end
          end
          SYNC, DATA: begin
            if (w_is_error) begin
              if (r_state == DATA) begin
                frame_abort <= 1'b1;
                in_frame    <= 1'b0;
              end
              r_state    <= HUNT;
              r_bit_cnt  <= 3'd0;
              r_byte_cnt <= '0;
            end else if (w_is_flag) begin
              // An aligned close leaves exactly the 7 flag-prefix bits pending.
              if (r_state == DATA) begin
                if ((r_bit_cnt == 3'd7) && (r_byte_cnt >= C_MIN_BYTES))
                  frame_end <= 1'b1;
                else
                  frame_abort <= 1'b1;
                in_frame <= 1'b0;
              end
              r_state    <= SYNC;
              r_bit_cnt  <= 3'd0;
              r_byte_cnt <= '0;
            end else if (w_is_data) begin
              r_asm <= w_asm_next;
              if (r_bit_cnt == 3'd7) begin
                r_bit_cnt <= 3'd0;
                if (r_byte_cnt == C_MAX_BYTES) begin
                  frame_abort <= 1'b1;
                  in_frame    <= 1'b0;
                  r_state     <= HUNT;
                  r_byte_cnt  <= C_SAT_BYTES;
                end else begin
                  byte_valid <= 1'b1;
                  byte_data  <= w_asm_next;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  if (r_state == SYNC) begin
                    frame_start <= 1'b1;
                    in_frame    <= 1'b1;
                    r_state     <= DATA;
                  end
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdlc_deframer.sv
`default_nettype none
// ============================================================================
// Module  : tb_hdlc_deframer
// Brief   : Randomised self-checking bench for hdlc_deframer with a
//           ones-run-count reference model compared every sampled cycle.
// Revision: 1.0  initial release
// ============================================================================
module tb_hdlc_deframer;

  localparam int MIN_B = 4;
  localparam int MAX_B = 64;

  logic       clk = 1'b0;
  logic       areset_n;
  logic       din_valid;
  logic       din;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_start;
  logic       frame_end;
  logic       frame_abort;
  logic       in_frame;

  int errors = 0;
  int checks = 0;

  hdlc_deframer #(.MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B)) dut (
    .clk         (clk),
    .areset_n    (areset_n),
    .din_valid   (din_valid),
    .din         (din),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_abort (frame_abort),
    .in_frame    (in_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bv;
    logic       fs;
    logic       fe;
    logic       fa;
    logic       inf;
    logic [7:0] data;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  // Reference model: run length of ones plus a frame mode (0 hunt, 1 sync, 2 data)
  int         m_ones, m_mode, m_nbits, m_nbytes;
  logic [7:0] m_shift, m_last;
  logic       m_in;
  int         tx_ones;

  task automatic model_reset();
    m_ones = 0; m_mode = 0; m_nbits = 0; m_nbytes = 0;
    m_shift = 8'h00; m_last = 8'h00; m_in = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit b, output rec_t e);
    int kind;
    e = '0;
    kind = 0;
    if (v) begin
      if (b) begin
        m_ones++;
        kind = (m_ones >= 7) ? 3 : 0;
      end else begin
        kind = (m_ones == 5) ? 1 : (m_ones == 6) ? 2 : 0;
        m_ones = 0;
      end
      if (kind == 2) begin
        if (m_mode == 2) begin
          if (m_nbits == 7 && m_nbytes >= MIN_B) e.fe = 1'b1;
          else e.fa = 1'b1;
          m_in = 1'b0;
        end
        m_mode = 1; m_nbits = 0; m_nbytes = 0;
      end else if (kind == 3) begin
        if (m_mode == 2) begin
          e.fa = 1'b1;
          m_in = 1'b0;
        end
        m_mode = 0;
      end else if (kind == 0 && m_mode != 0) begin
        m_shift[m_nbits] = b;
        m_nbits++;
        if (m_nbits == 8) begin
          m_nbits = 0;
          if (m_nbytes == MAX_B) begin
            e.fa = 1'b1; m_in = 1'b0; m_mode = 0;
          end else begin
            e.bv = 1'b1; m_last = m_shift; m_nbytes++;
            if (m_mode == 1) begin
              e.fs = 1'b1; m_in = 1'b1; m_mode = 2;
            end
          end
        end
      end
    end
    e.inf  = m_in;
    e.data = m_last;
  endtask

  task automatic drive(input bit v, input bit b);
    rec_t e;
    rec_t o;
    @(negedge clk);
    din_valid = v;
    din       = b;
    model_step(v, b, e);
    @(posedge clk);
    #1;
    o.bv = byte_valid; o.fs = frame_start; o.fe = frame_end;
    o.fa = frame_abort; o.inf = in_frame; o.data = byte_data;
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic send_stuffed(input bit b);
    drive(1'b1, b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        drive(1'b1, 1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_stuffed(v[i]);
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) drive(1'b1, f[i]);
    tx_ones = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic clear_q();
    exp_q.delete();
    obs_q.delete();
  endtask

  function automatic int count_obs(input int sel);
    int n;
    n = 0;
    foreach (obs_q[i]) begin
      case (sel)
        0: if (obs_q[i].bv) n++;
        1: if (obs_q[i].fs) n++;
        2: if (obs_q[i].fe) n++;
        default: if (obs_q[i].fa) n++;
      endcase
    end
    return n;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
    checks++;
    if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h want 00", byte_data); end
    checks++;
    if ({frame_start, frame_end, frame_abort} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b want 000", {frame_start, frame_end, frame_abort});
    end
    checks++;
    if (in_frame !== 1'b0) begin errors++; $display("FAIL reset_in_frame: got %b want 0", in_frame); end
  endtask

  task automatic test_basic();
    logic [7:0] want [4];
    logic [7:0] got  [$];
    want = '{8'h12, 8'h34, 8'h56, 8'h78};
    clear_q();
    send_flag();
    for (int k = 0; k < 4; k++) send_byte(want[k]);
    send_flag();
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    foreach (obs_q[i]) if (obs_q[i].bv) got.push_back(obs_q[i].data);
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL basic_byte_count: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== want[k]) begin errors++; $display("FAIL basic_byte[%0d]: got %h want %h", k, got[k], want[k]); end
    end
    checks++;
    if (count_obs(2) != 1) begin errors++; $display("FAIL basic_frame_end: got %0d want 1", count_obs(2)); end
    checks++;
    if (in_frame !== 1'b0) begin errors++; $display("FAIL basic_in_frame_after: got %b want 0", in_frame); end
  endtask

  task automatic test_stuffing();
    logic [7:0] fixed [4];
    int total;
    fixed = '{8'hFF, 8'h3E, 8'h00, 8'h01};
    total = 4;
    clear_q();
    send_flag();
    for (int k = 0; k < 4; k++) send_byte(fixed[k]);
    send_flag();
    for (int f = 0; f < 3; f++) begin
      int len;
      len = $urandom_range(MIN_B, 12);
      total += len;
      for (int k = 0; k < len; k++) send_byte(8'($urandom));
      send_flag();
    end
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stuff_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (count_obs(2) != 4) begin errors++; $display("FAIL stuff_frame_end: got %0d want 4", count_obs(2)); end
    checks++;
    if (count_obs(0) != total) begin errors++; $display("FAIL stuff_byte_count: got %0d want %0d", count_obs(0), total); end
    checks++;
    if (count_obs(3) != 0) begin errors++; $display("FAIL stuff_abort: got %0d want 0", count_obs(3)); end
  endtask

  task automatic test_short();
    clear_q();
    send_flag();
    send_byte(8'hAA);
    send_byte(8'h55);
    send_flag();
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    send_flag();
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (count_obs(3) != 1) begin errors++; $display("FAIL short_abort: got %0d want 1", count_obs(3)); end
    checks++;
    if (count_obs(2) != 1) begin errors++; $display("FAIL short_frame_end: got %0d want 1", count_obs(2)); end
  endtask

  task automatic test_error();
    clear_q();
    send_flag();
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    for (int k = 0; k < 8; k++) drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    tx_ones = 0;
    for (int k = 0; k < 2; k++) send_byte(8'($urandom));
    send_flag();
    for (int k = 0; k < 4; k++) send_byte(8'($urandom));
    send_flag();
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL error_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (count_obs(3) != 1) begin errors++; $display("FAIL error_abort: got %0d want 1", count_obs(3)); end
    checks++;
    if (count_obs(0) != 7) begin errors++; $display("FAIL error_byte_count: got %0d want 7", count_obs(0)); end
    checks++;
    if (count_obs(2) != 1) begin errors++; $display("FAIL error_frame_end: got %0d want 1", count_obs(2)); end
  endtask

  task automatic test_misaligned();
    logic [7:0] want [4];
    logic [7:0] got  [$];
    clear_q();
    send_flag();
    send_byte(8'($urandom));
    for (int k = 0; k < 3; k++) send_stuffed(1'($urandom_range(0, 1)));
    send_flag();
    checks++;
    if (count_obs(3) != 1 || count_obs(2) != 0) begin
      errors++; $display("FAIL misalign_abort: aborts %0d ends %0d want 1 0", count_obs(3), count_obs(2));
    end
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL misalign_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    clear_q();
    send_flag(); send_flag(); send_flag();
    checks++;
    if (count_obs(0) + count_obs(1) + count_obs(2) + count_obs(3) != 0) begin
      errors++; $display("FAIL b2b_flags_strobes: got %0d want 0", count_obs(0) + count_obs(1) + count_obs(2) + count_obs(3));
    end
    clear_q();
    for (int k = 0; k < 4; k++) want[k] = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (k == 1 && i == 3) idle(5);
        send_stuffed(want[k][i]);
      end
    end
    send_flag();
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    foreach (obs_q[i]) if (obs_q[i].bv) got.push_back(obs_q[i].data);
    checks++;
    if (got.size() != 4) begin errors++; $display("FAIL stall_byte_count: got %0d want 4", got.size()); end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== want[k]) begin errors++; $display("FAIL stall_byte[%0d]: got %h want %h", k, got[k], want[k]); end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    send_flag();
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    for (int k = 0; k < 4; k++) send_stuffed(1'($urandom_range(0, 1)));
    checks++;
    if (in_frame !== 1'b1) begin errors++; $display("FAIL rstmid_pre_in_frame: got %b want 1", in_frame); end
    #2 areset_n = 1'b0;
    model_reset();
    tx_ones = 0;
    #1;
    checks++;
    if ({byte_valid, frame_start, frame_end, frame_abort, in_frame, byte_data} !== 13'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %h want 0000",
                         {byte_valid, frame_start, frame_end, frame_abort, in_frame, byte_data});
    end
    clear_q();
    idle(2);
    @(negedge clk) areset_n = 1'b1;
    send_flag();
    for (int k = 0; k < 5; k++) send_byte(8'($urandom));
    send_flag();
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (count_obs(2) != 1 || count_obs(3) != 0) begin
      errors++; $display("FAIL rstmid_after: ends %0d aborts %0d want 1 0", count_obs(2), count_obs(3));
    end
  endtask

  task automatic test_overflow();
    clear_q();
    send_flag();
    for (int k = 0; k < MAX_B + 1; k++) send_byte(8'($urandom));
    send_flag();
    idle(2);
    foreach (obs_q[i]) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_stream[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (count_obs(0) != MAX_B) begin errors++; $display("FAIL ovf_byte_count: got %0d want %0d", count_obs(0), MAX_B); end
    checks++;
    if (count_obs(3) != 1 || count_obs(2) != 0) begin
      errors++; $display("FAIL ovf_abort: aborts %0d ends %0d want 1 0", count_obs(3), count_obs(2));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n  = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    tx_ones   = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) areset_n = 1'b1;
    test_reset();
    test_basic();
    test_stuffing();
    test_short();
    test_error();
    test_misaligned();
    test_reset_mid();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
